// File: rtl/ansi_commands.sv
// Byte-serial recognizer for ANSI CSI sequences and the shell words "clear" and "uname -a".
// One character per clock; each recognized command gives a one-cycle Moore strobe.
module ansi_commands (
  input  logic       clk,
  input  logic       _rst,
  input  logic [7:0] in,
  output logic [6:0] str,
  output logic       Delete,
  output logic       CUF,
  output logic       CUB,
  output logic       CNL,
  output logic       CPL,
  output logic       CHA,
  output logic       CUP,
  output logic       ED,
  output logic       EL,
  output logic       SU,
  output logic       SD,
  output logic       HVP,
  output logic       SCP,
  output logic       RCP,
  output logic       Clear,
  output logic       Uname,
  output logic [4:0] state,
  output logic [4:0] nextstate
);

  typedef enum logic [4:0] {
    StIdle   = 5'd0,  StEsc   = 5'd1,  StCsi   = 5'd2,  StCsi3  = 5'd3,
    StC      = 5'd4,  StCl    = 5'd5,  StCle   = 5'd6,  StClea  = 5'd7,
    StU      = 5'd8,  StUn    = 5'd9,  StUna   = 5'd10, StUnam  = 5'd11,
    StUname  = 5'd12, StUnsp  = 5'd13, StUndash = 5'd14,
    StDel    = 5'd15, StCuf   = 5'd16, StCub   = 5'd17, StCnl   = 5'd18,
    StCpl    = 5'd19, StCha   = 5'd20, StCup   = 5'd21, StEd    = 5'd22,
    StEl     = 5'd23, StSu    = 5'd24, StSd    = 5'd25, StHvp   = 5'd26,
    StScp    = 5'd27, StRcp   = 5'd28, StClear = 5'd29, StUnameCmd = 5'd30
  } state_e;

  state_e state_q, state_d;
  logic [6:0] str_q;

  // Entry point shared by idle, command states and every mismatch.
  function automatic state_e restart(input logic [7:0] b);
    unique case (b)
      8'd27:   restart = StEsc;
      8'd99:   restart = StC;
      8'd117:  restart = StU;
      default: restart = StIdle;
    endcase
  endfunction

  // Advance along a literal-word chain only when the expected byte arrives.
  function automatic state_e step(input logic [7:0] b, input logic [7:0] want, input state_e nxt);
    step = (b == want) ? nxt : restart(b);
  endfunction

  always_comb begin
    state_d = StIdle;
    unique case (state_q)
      StEsc:    state_d = step(in, 8'd91, StCsi);
      StCsi: begin
        unique case (in)
          8'd67:   state_d = StCuf;
          8'd68:   state_d = StCub;
          8'd69:   state_d = StCnl;
          8'd70:   state_d = StCpl;
          8'd71:   state_d = StCha;
          8'd72:   state_d = StCup;
          8'd74:   state_d = StEd;
          8'd75:   state_d = StEl;
          8'd83:   state_d = StSu;
          8'd84:   state_d = StSd;
          8'd102:  state_d = StHvp;
          8'd115:  state_d = StScp;
          8'd117:  state_d = StRcp;
          8'd51:   state_d = StCsi3;
          default: state_d = restart(in);
        endcase
      end
      StCsi3:   state_d = step(in, 8'd126, StDel);
      StC:      state_d = step(in, 8'd108, StCl);
      StCl:     state_d = step(in, 8'd101, StCle);
      StCle:    state_d = step(in, 8'd97,  StClea);
      StClea:   state_d = step(in, 8'd114, StClear);
      StU:      state_d = step(in, 8'd110, StUn);
      StUn:     state_d = step(in, 8'd97,  StUna);
      StUna:    state_d = step(in, 8'd109, StUnam);
      StUnam:   state_d = step(in, 8'd101, StUname);
      StUname:  state_d = step(in, 8'd32,  StUnsp);
      StUnsp:   state_d = step(in, 8'd45,  StUndash);
      StUndash: state_d = step(in, 8'd97,  StUnameCmd);
      StIdle, StDel, StCuf, StCub, StCnl, StCpl, StCha, StCup, StEd, StEl,
      StSu, StSd, StHvp, StScp, StRcp, StClear, StUnameCmd:
                state_d = restart(in);
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q <= StIdle;
      str_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      str_q   <= in[6:0];
    end
  end

  assign str       = str_q;
  assign state     = state_q;
  assign nextstate = state_d;

  assign Delete = (state_q == StDel);
  assign CUF    = (state_q == StCuf);
  assign CUB    = (state_q == StCub);
  assign CNL    = (state_q == StCnl);
  assign CPL    = (state_q == StCpl);
  assign CHA    = (state_q == StCha);
  assign CUP    = (state_q == StCup);
  assign ED     = (state_q == StEd);
  assign EL     = (state_q == StEl);
  assign SU     = (state_q == StSu);
  assign SD     = (state_q == StSd);
  assign HVP    = (state_q == StHvp);
  assign SCP    = (state_q == StScp);
  assign RCP    = (state_q == StRcp);
  assign Clear  = (state_q == StClear);
  assign Uname  = (state_q == StUnameCmd);

endmodule

// File: tb/tb_ansi_commands.sv
// Directed bench: each driven byte pushes its expected state/echo to a queue,
// popped and checked one cycle later.
module tb_ansi_commands;

  logic       clk = 1'b0;
  logic       _rst;
  logic [7:0] in;
  logic [6:0] str;
  logic       Delete, CUF, CUB, CNL, CPL, CHA, CUP, ED, EL, SU, SD, HVP, SCP, RCP, Clear, Uname;
  logic [4:0] state, nextstate;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0] st;
    logic [6:0] echo;
  } exp_t;
  exp_t sb[$];

  ansi_commands dut (
    .clk(clk), ._rst(_rst), .in(in), .str(str),
    .Delete(Delete), .CUF(CUF), .CUB(CUB), .CNL(CNL), .CPL(CPL), .CHA(CHA), .CUP(CUP),
    .ED(ED), .EL(EL), .SU(SU), .SD(SD), .HVP(HVP), .SCP(SCP), .RCP(RCP),
    .Clear(Clear), .Uname(Uname), .state(state), .nextstate(nextstate)
  );

  always #5 clk = ~clk;

  wire [15:0] strobes = {Delete, CUF, CUB, CNL, CPL, CHA, CUP, ED, EL, SU, SD, HVP, SCP,
                         RCP, Clear, Uname};

  // Command states 15..30 map one-to-one onto strobes, Delete first.
  function automatic logic [15:0] strobe_of(input logic [4:0] s);
    logic [15:0] v;
    v = 16'd0;
    if (s >= 5'd15 && s <= 5'd30) v[30 - int'(s)] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic [4:0] exp_st);
    exp_t e;
    in = b;
    e.st = exp_st;
    e.echo = b[6:0];
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("state after %0d", b), 32'(state), 32'(e.st));
    chk($sformatf("strobes after %0d", b), 32'(strobes), 32'(strobe_of(e.st)));
    chk($sformatf("str after %0d", b), 32'(str), 32'(e.echo));
  endtask

  logic [7:0] finals[13] = '{8'd67, 8'd68, 8'd69, 8'd70, 8'd71, 8'd72, 8'd74, 8'd75,
                             8'd83, 8'd84, 8'd102, 8'd115, 8'd117};
  logic [4:0] fstates[13] = '{5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
                              5'd24, 5'd25, 5'd26, 5'd27, 5'd28};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    _rst = 1'b0;
    in   = 8'd27;
    #1;
    chk("reset state", 32'(state), 32'd0);
    chk("reset str", 32'(str), 32'd0);
    chk("reset strobes", 32'(strobes), 32'd0);
    chk("nextstate in reset", 32'(nextstate), 32'd1);
    in = 8'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    _rst = 1'b1;

    // Delete sequence
    send(8'd27, 5'd1); send(8'd91, 5'd2); send(8'd51, 5'd3); send(8'd126, 5'd15);
    send(8'd0, 5'd0);

    foreach (finals[i]) begin
      send(8'd27, 5'd1); send(8'd91, 5'd2); send(finals[i], fstates[i]); send(8'd0, 5'd0);
    end

    // "clear"
    send(8'd99, 5'd4); send(8'd108, 5'd5); send(8'd101, 5'd6); send(8'd97, 5'd7);
    send(8'd114, 5'd29); send(8'd0, 5'd0);

    // "uname -a"
    send(8'd117, 5'd8); send(8'd110, 5'd9); send(8'd97, 5'd10); send(8'd109, 5'd11);
    send(8'd101, 5'd12); send(8'd32, 5'd13); send(8'd45, 5'd14); send(8'd97, 5'd30);
    send(8'd0, 5'd0);

    // Aborts and restarts
    send(8'd27, 5'd1); send(8'd91, 5'd2); send(8'd90, 5'd0);
    send(8'd27, 5'd1); send(8'd27, 5'd1); send(8'd91, 5'd2); send(8'd67, 5'd16);
    send(8'd0, 5'd0);
    send(8'd99, 5'd4); send(8'd108, 5'd5); send(8'd99, 5'd4); send(8'd108, 5'd5);
    send(8'd101, 5'd6); send(8'd97, 5'd7); send(8'd114, 5'd29); send(8'd0, 5'd0);
    send(8'd99, 5'd4); send(8'd99, 5'd4); send(8'd27, 5'd1); send(8'd99, 5'd4);
    send(8'd117, 5'd8); send(8'd0, 5'd0);
    send(8'd27, 5'd1); send(8'd91, 5'd2); send(8'd53, 5'd0); send(8'd67, 5'd0);

    // Back-to-back commands, restart straight from a command state
    send(8'd27, 5'd1); send(8'd91, 5'd2); send(8'd67, 5'd16);
    send(8'd27, 5'd1); send(8'd91, 5'd2); send(8'd68, 5'd17);
    send(8'd99, 5'd4); send(8'd27, 5'd1); send(8'd91, 5'd2); send(8'd117, 5'd28);
    send(8'd117, 5'd8);

    // Bit 7 is dropped from the echo
    send(8'hA0, 5'd0);

    // Async reset between '[' and the final byte
    send(8'd27, 5'd1); send(8'd91, 5'd2);
    #2;
    _rst = 1'b0;
    #1;
    chk("async reset state", 32'(state), 32'd0);
    chk("async reset str", 32'(str), 32'd0);
    chk("async reset strobes", 32'(strobes), 32'd0);
    in = 8'd67;
    @(posedge clk);
    #1;
    chk("held reset state", 32'(state), 32'd0);
    chk("held reset strobes", 32'(strobes), 32'd0);
    _rst = 1'b1;
    send(8'd67, 5'd0);
    send(8'd0, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
